ema_channel_scheduler: RTL and testbench

EMA_CHANNEL_SCHEDULER -- requirements
Module: ema_channel_scheduler

---
 rtl/ema_pkg.sv | 30 +++
 rtl/ema_channel_scheduler_rr_arbiter.sv | 54 +++++
 rtl/ema_channel_scheduler.sv | 105 ++++++++++
 tb/tb_ema_channel_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ema_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ema_pkg : shared widths and the EMA step used by the channel scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
package ema_pkg;

  localparam int Q_W     = 32;
  localparam int EXT_W   = 48;
  localparam int ALPHA_W = 3;

  // Widened so the difference of two Q16.16 values never overflows before the shift.
  function automatic logic [Q_W-1:0] ema_step(
    input logic [Q_W-1:0]     avg,
    input logic [Q_W-1:0]     price,
    input logic [ALPHA_W-1:0] alpha
  );
    logic signed [EXT_W-1:0] avg_x;
    logic signed [EXT_W-1:0] price_x;
    logic signed [EXT_W-1:0] delta;
    logic signed [EXT_W-1:0] sum;
    avg_x   = {{(EXT_W-Q_W){avg[Q_W-1]}}, avg};
    price_x = {{(EXT_W-Q_W){price[Q_W-1]}}, price};
    delta   = price_x - avg_x;
    sum     = avg_x + (delta >>> alpha);
    return sum[Q_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ema_channel_scheduler_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin grant with pointer advance past the accepted request
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic             accept_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr_q) + k) % N;
      if (!rst && !found && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
        found      = 1'b1;
      end
    end
    accept_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_o) begin
      ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ema_channel_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ema_channel_scheduler : NCH price channels time-sharing one EMA datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
module ema_channel_scheduler
  import ema_pkg::*;
#(
  parameter  int NCH           = 4,
  parameter  int ALPHA_DEFAULT = 4,
  localparam int CH_W          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req_valid,
  input  logic [32*NCH-1:0]  req_price,
  output logic [NCH-1:0]     req_ready,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [ALPHA_W-1:0] cfg_alpha,
  input  logic               cfg_reseed,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [Q_W-1:0]     out_avg
);

  logic [Q_W-1:0]     avg_q    [NCH];
  logic               seeded_q [NCH];
  logic [ALPHA_W-1:0] alpha_q  [NCH];

  logic               out_valid_q;
  logic [CH_W-1:0]    out_ch_q;
  logic [Q_W-1:0]     out_avg_q;

  logic               accept;
  logic [CH_W-1:0]    sel;
  logic [Q_W-1:0]     sel_price;
  logic               reseed_hit;
  logic [Q_W-1:0]     avg_d;

  rr_arbiter #(
    .N     (NCH),
    .IDX_W (CH_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid),
    .grant_o  (req_ready),
    .accept_o (accept),
    .idx_o    (sel)
  );

  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == CH_W'(i)) begin
        sel_price = req_price[32*i +: 32];
      end
    end
  end

  // A same-cycle reseed turns the accepted sample into a seeding sample.
  assign reseed_hit = cfg_we && cfg_reseed && (cfg_ch == sel);

  always_comb begin
    avg_d = sel_price;
    if (seeded_q[sel] && !reseed_hit) begin
      avg_d = ema_step(avg_q[sel], sel_price, alpha_q[sel]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        avg_q[i]    <= '0;
        seeded_q[i] <= 1'b0;
        alpha_q[i]  <= ALPHA_W'(ALPHA_DEFAULT);
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_avg_q   <= '0;
    end else begin
      out_valid_q <= accept;
      if (cfg_we) begin
        alpha_q[cfg_ch] <= cfg_alpha;
        if (cfg_reseed) begin
          seeded_q[cfg_ch] <= 1'b0;
        end
      end
      // Placed after the config write so an accepted sample always leaves its channel seeded.
      if (accept) begin
        avg_q[sel]    <= avg_d;
        seeded_q[sel] <= 1'b1;
        out_ch_q      <= sel;
        out_avg_q     <= avg_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_avg   = out_avg_q;

endmodule
`default_nettype wire

// File: tb/tb_ema_channel_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ema_channel_scheduler : randomized + directed checks against a reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ema_channel_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_price;
  logic [3:0]   req_ready;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [2:0]   cfg_alpha;
  logic         cfg_reseed;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic [31:0]  out_avg;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_avg   [4];
  bit          m_seed  [4];
  int          m_alpha [4];
  int          m_ptr;
  bit          e_valid;
  int          e_ch;
  logic [31:0] e_avg;

  ema_channel_scheduler #(
    .NCH           (4),
    .ALPHA_DEFAULT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_price  (req_price),
    .req_ready  (req_ready),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_alpha  (cfg_alpha),
    .cfg_reseed (cfg_reseed),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_avg    (out_avg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // EMA as floor((price - avg) / 2^alpha) added to avg, modulo 2^32.
  function automatic logic [31:0] ref_ema(input logic [31:0] avg, input logic [31:0] price, input int a);
    longint d, p, q;
    d = longint'($signed(price)) - longint'($signed(avg));
    p = longint'(1) << a;
    q = d / p;
    if (d < 0 && (d % p) != 0) q = q - 1;
    return 32'(longint'($signed(avg)) + q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_avg[i] = '0; m_seed[i] = 0; m_alpha[i] = 4;
    end
    m_ptr = 0; e_valid = 0; e_ch = 0; e_avg = '0;
  endtask

  task automatic clr_inputs();
    req_valid = '0; req_price = '0;
    cfg_we = 0; cfg_ch = '0; cfg_alpha = '0; cfg_reseed = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    int g;
    logic [31:0] price, nv;
    logic [3:0] exp_ready;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (g < 0 && req_valid[j]) g = j;
    end
    exp_ready = (g >= 0 && !rst) ? 4'(1 << g) : 4'b0;
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    if (rst) begin
      model_reset();
    end else begin
      nv = '0;
      if (g >= 0) begin
        price = req_price[32*g +: 32];
        if (m_seed[g] && !(cfg_we && cfg_reseed && int'(cfg_ch) == g))
          nv = ref_ema(m_avg[g], price, m_alpha[g]);
        else
          nv = price;
      end
      if (cfg_we) begin
        m_alpha[cfg_ch] = int'(cfg_alpha);
        if (cfg_reseed) m_seed[cfg_ch] = 0;
      end
      if (g >= 0) begin
        m_avg[g] = nv; m_seed[g] = 1; m_ptr = (g + 1) % 4;
        e_valid = 1; e_ch = g; e_avg = nv;
      end else begin
        e_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(e_valid));
    check_eq("out_ch", 64'(out_ch), 64'(e_ch));
    check_eq("out_avg", 64'(out_avg), 64'(e_avg));
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    clr_inputs();
    rst = 1;
    for (int i = 0; i < n; i++) cycle();
    rst = 0;
  endtask

  task automatic send(input int ch, input logic [31:0] price);
    clr_inputs();
    req_valid[ch] = 1'b1;
    req_price[32*ch +: 32] = price;
    cycle();
  endtask

  initial begin
    rst = 1;
    clr_inputs();
    model_reset();
    @(negedge clk);
    do_reset(2);
    check_eq("reset_out_avg", 64'(out_avg), 64'h0);

    // Seed, then rising and falling updates on ch0 with the default shift.
    send(0, 32'h000A0000);
    check_eq("seed_ch0", 64'(out_avg), 64'h000A0000);
    send(0, 32'h001A0000);
    check_eq("ema_up_ch0", 64'(out_avg), 64'h000B0000);
    send(0, 32'h00010000);
    check_eq("ema_down_ch0", 64'(out_avg), 64'h000A6000);

    // Fair rotation from pointer 0 with all channels requesting.
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      clr_inputs();
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) req_price[32*i +: 32] = 32'(i + 1) << 16;
      cycle();
      check_eq("rr_order", 64'(out_ch), 64'(k));
    end

    // Same-cycle reseed on ch2, then a normal EMA on ch2.
    send(2, 32'h00100000);
    clr_inputs();
    req_valid[2] = 1'b1;
    req_price[95:64] = 32'h00050000;
    cfg_we = 1; cfg_ch = 2'd2; cfg_alpha = 3'd4; cfg_reseed = 1;
    cycle();
    check_eq("reseed_ch2", 64'(out_avg), 64'h00050000);
    send(2, 32'h00150000);
    check_eq("ema_after_reseed", 64'(out_avg), 64'h00060000);

    // Shift 0 tracks the price exactly.
    clr_inputs();
    cfg_we = 1; cfg_ch = 2'd1; cfg_alpha = 3'd0;
    cycle();
    send(1, 32'h00030000);
    check_eq("alpha0_ch1", 64'(out_avg), 64'h00030000);

    // Reset in the middle of traffic, then every channel reseeds.
    clr_inputs();
    req_valid = 4'hF;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    for (int i = 0; i < 4; i++) req_price[32*i +: 32] = 32'h00200000 + 32'(i);
    for (int k = 0; k < 4; k++) cycle();

    // Randomized traffic with occasional config writes and resets.
    for (int n = 0; n < 400; n++) begin
      clr_inputs();
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) req_price[32*i +: 32] = $urandom();
        else req_price[32*i +: 32] = 32'($urandom_range(0, 32'h00400000));
      end
      if ($urandom_range(0, 5) == 0) begin
        cfg_we = 1;
        cfg_ch = 2'($urandom_range(0, 3));
        cfg_alpha = 3'($urandom_range(0, 7));
        cfg_reseed = ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
